// File: rtl/tick_sched_pkg.sv
// Shared types and defaults for the tick scheduler.
// Contents: command and channel-state enums, default parameter values and a
// channel-index width helper used by the top level and by tick_channel.
package tick_sched_pkg;

  localparam int unsigned DEF_NUM_CH   = 4;
  localparam int unsigned DEF_PRESCALE = 50;
  localparam int unsigned DEF_PERIOD_W = 24;
  localparam int unsigned CMD_W        = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_STOP       = 2'b00,
    CMD_START_PER  = 2'b01,
    CMD_START_ONE  = 2'b10,
    CMD_SET_PERIOD = 2'b11
  } cmd_e;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One scheduled channel: period register, countdown, IDLE/RUN FSM and
// (with TICK_SCHED_TOGGLE_EN defined) a square-wave toggle flop.
// Ports:
//   clk50, rst_n   clock, asynchronous active-low reset
//   cmd_valid_i    an accepted command addresses this channel this cycle
//   cmd_i          decoded command
//   period_i       period operand for CMD_SET_PERIOD
//   base_tick_i    shared base-tick pulse from the prescaler
//   tick_o         registered one-cycle expiry pulse
//   busy_o         registered, high while in RUN
//   toggle_o       registered square wave (TICK_SCHED_TOGGLE_EN only)
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int unsigned PERIOD_W = DEF_PERIOD_W
) (
  input  logic                clk50,
  input  logic                rst_n,
  input  logic                cmd_valid_i,
  input  cmd_e                cmd_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic                base_tick_i,
  output logic                tick_o,
`ifdef TICK_SCHED_TOGGLE_EN
  output logic                busy_o,
  output logic                toggle_o
`else
  output logic                busy_o
`endif
);

  ch_state_e           state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                oneshot_q, oneshot_d;
  logic                expire_c;
  logic                tick_q, tick_d;
  logic                busy_q, busy_d;
`ifdef TICK_SCHED_TOGGLE_EN
  logic                toggle_q, toggle_d;
`endif

  // State, datapath and output registers.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CH_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      oneshot_q <= 1'b0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef TICK_SCHED_TOGGLE_EN
      toggle_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      oneshot_q <= oneshot_d;
      tick_q    <= tick_d;
      busy_q    <= busy_d;
`ifdef TICK_SCHED_TOGGLE_EN
      toggle_q  <= toggle_d;
`endif
    end
  end

  // Next state. A command to this channel takes priority over the base tick,
  // so a base tick coinciding with any command is neither counted nor fired.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    oneshot_d = oneshot_q;
    expire_c  = 1'b0;

    if (cmd_valid_i) begin
      unique case (cmd_i)
        CMD_STOP: begin
          state_d = CH_IDLE;
        end
        CMD_START_PER, CMD_START_ONE: begin
          if (period_q != '0) begin
            state_d   = CH_RUN;
            cnt_d     = period_q;
            oneshot_d = (cmd_i == CMD_START_ONE);
          end else begin
            // A zero period cannot be counted; the channel parks in IDLE.
            state_d = CH_IDLE;
          end
        end
        CMD_SET_PERIOD: begin
          period_d = period_i;
        end
        default: ;
      endcase
    end else if ((state_q == CH_RUN) && base_tick_i) begin
      if (cnt_q > PERIOD_W'(1)) begin
        cnt_d = cnt_q - PERIOD_W'(1);
      end else begin
        expire_c = 1'b1;
        // Reload uses the latest period; a zero period ends the run here.
        if (!oneshot_q && (period_q != '0)) begin
          cnt_d = period_q;
        end else begin
          state_d = CH_IDLE;
          cnt_d   = '0;
        end
      end
    end
  end

  // Output next values; busy tracks the state register edge-for-edge.
  always_comb begin
    tick_d   = expire_c;
    busy_d   = (state_d == CH_RUN);
`ifdef TICK_SCHED_TOGGLE_EN
    toggle_d = toggle_q ^ expire_c;
`endif
  end

  assign tick_o   = tick_q;
  assign busy_o   = busy_q;
`ifdef TICK_SCHED_TOGGLE_EN
  assign toggle_o = toggle_q;
`endif

endmodule

// File: rtl/tick_scheduler.sv
// Shared timebase: a free-running prescaler produces base_tick every PRESCALE
// clk50 cycles; NUM_CH independent channels count base ticks and pulse ch_tick.
// Optional feature macro: TICK_SCHED_TOGGLE_EN adds the ch_toggle port.
// Ports:
//   clk50, rst_n  clock, asynchronous active-low reset
//   cfg_valid     command valid
//   cfg_ready     command ready (registered, 1 from the first edge after reset)
//   cfg_ch        target channel; values >= NUM_CH are accepted and dropped
//   cfg_cmd       00 STOP, 01 START_PERIODIC, 10 START_ONESHOT, 11 SET_PERIOD
//   cfg_period    period operand for SET_PERIOD
//   base_tick     one-cycle pulse every PRESCALE cycles
//   ch_tick       per-channel one-cycle expiry pulse
//   ch_busy       per-channel RUN indicator
//   ch_toggle     per-channel square wave (TICK_SCHED_TOGGLE_EN only)
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned NUM_CH   = DEF_NUM_CH,
  parameter int unsigned PRESCALE = DEF_PRESCALE,
  parameter int unsigned PERIOD_W = DEF_PERIOD_W
) (
  input  logic                                         clk50,
  input  logic                                         rst_n,
  input  logic                                         cfg_valid,
  output logic                                         cfg_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [CMD_W-1:0]                             cfg_cmd,
  input  logic [PERIOD_W-1:0]                          cfg_period,
  output logic                                         base_tick,
  output logic [NUM_CH-1:0]                            ch_tick,
`ifdef TICK_SCHED_TOGGLE_EN
  output logic [NUM_CH-1:0]                            ch_busy,
  output logic [NUM_CH-1:0]                            ch_toggle
`else
  output logic [NUM_CH-1:0]                            ch_busy
`endif
);

  localparam int unsigned CH_W   = ch_idx_w(NUM_CH);
  localparam int unsigned PCNT_W = $clog2(PRESCALE);

  logic              cfg_ready_q;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              base_tick_q, base_tick_d;
  logic              cmd_accept_c;
  cmd_e              cmd_c;
  logic [NUM_CH-1:0] ch_sel_c;

  // Ready rises on the first edge after reset and stays high.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready_q <= 1'b0;
    end else begin
      cfg_ready_q <= 1'b1;
    end
  end

  // Free-running prescaler; commands never disturb it.
  always_comb begin
    pcnt_d      = pcnt_q + PCNT_W'(1);
    base_tick_d = 1'b0;
    if (pcnt_q == PCNT_W'(PRESCALE - 1)) begin
      pcnt_d      = '0;
      base_tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q      <= '0;
      base_tick_q <= 1'b0;
    end else begin
      pcnt_q      <= pcnt_d;
      base_tick_q <= base_tick_d;
    end
  end

  // Command decode: one-hot channel select; out-of-range indices match nothing.
  assign cmd_accept_c = cfg_valid && cfg_ready_q;
  assign cmd_c        = cmd_e'(cfg_cmd);

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    assign ch_sel_c[i] = cmd_accept_c && (cfg_ch == CH_W'(i));

    tick_channel #(
      .PERIOD_W (PERIOD_W)
    ) u_ch (
      .clk50       (clk50),
      .rst_n       (rst_n),
      .cmd_valid_i (ch_sel_c[i]),
      .cmd_i       (cmd_c),
      .period_i    (cfg_period),
      .base_tick_i (base_tick_q),
      .tick_o      (ch_tick[i]),
`ifdef TICK_SCHED_TOGGLE_EN
      .busy_o      (ch_busy[i]),
      .toggle_o    (ch_toggle[i])
`else
      .busy_o      (ch_busy[i])
`endif
    );
  end

  assign cfg_ready = cfg_ready_q;
  assign base_tick = base_tick_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler (PRESCALE=4, NUM_CH=4, PERIOD_W=8), plus a
// NUM_CH=5 instance used to reach an out-of-range channel index.
module tb_tick_scheduler;
  import tick_sched_pkg::*;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned PRESCALE = 4;
  localparam int unsigned PERIOD_W = 8;

  logic                clk50 = 1'b0;
  logic                rst_n = 1'b0;

  logic                cfg_valid  = 1'b0;
  logic                cfg_ready;
  logic [1:0]          cfg_ch     = '0;
  logic [1:0]          cfg_cmd    = '0;
  logic [PERIOD_W-1:0] cfg_period = '0;
  logic                base_tick;
  logic [NUM_CH-1:0]   ch_tick;
  logic [NUM_CH-1:0]   ch_busy;
  logic [NUM_CH-1:0]   ch_toggle;

  logic                cfg_valid5  = 1'b0;
  logic                cfg_ready5;
  logic [2:0]          cfg_ch5     = '0;
  logic [1:0]          cfg_cmd5    = '0;
  logic [PERIOD_W-1:0] cfg_period5 = '0;
  logic                base_tick5;
  logic [4:0]          ch_tick5;
  logic [4:0]          ch_busy5;
  logic [4:0]          ch_toggle5;

  int errors = 0;
  int checks = 0;

  always #5 clk50 = ~clk50;

  tick_scheduler #(
    .NUM_CH   (NUM_CH),
    .PRESCALE (PRESCALE),
    .PERIOD_W (PERIOD_W)
  ) u_dut (
    .clk50      (clk50),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_cmd    (cfg_cmd),
    .cfg_period (cfg_period),
    .base_tick  (base_tick),
    .ch_tick    (ch_tick),
`ifdef TICK_SCHED_TOGGLE_EN
    .ch_busy    (ch_busy),
    .ch_toggle  (ch_toggle)
`else
    .ch_busy    (ch_busy)
`endif
  );

  tick_scheduler #(
    .NUM_CH   (5),
    .PRESCALE (PRESCALE),
    .PERIOD_W (PERIOD_W)
  ) u_dut5 (
    .clk50      (clk50),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid5),
    .cfg_ready  (cfg_ready5),
    .cfg_ch     (cfg_ch5),
    .cfg_cmd    (cfg_cmd5),
    .cfg_period (cfg_period5),
    .base_tick  (base_tick5),
    .ch_tick    (ch_tick5),
`ifdef TICK_SCHED_TOGGLE_EN
    .ch_busy    (ch_busy5),
    .ch_toggle  (ch_toggle5)
`else
    .ch_busy    (ch_busy5)
`endif
  );

`ifndef TICK_SCHED_TOGGLE_EN
  assign ch_toggle  = '0;
  assign ch_toggle5 = '0;
`endif

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk50);
    #1;
  endtask

  // Present one command for one cycle (ready is constantly high after reset).
  task automatic send_cmd(input logic [1:0] ch, input cmd_e cmd,
                          input logic [PERIOD_W-1:0] per);
    cfg_valid  = 1'b1;
    cfg_ch     = ch;
    cfg_cmd    = cmd;
    cfg_period = per;
    step();
    cfg_valid  = 1'b0;
    cfg_period = '0;
  endtask

  // Align to a sample where base_tick is high.
  task automatic sync_bt();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (base_tick) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL sync_bt: base_tick got 0 for 8 cycles, required a pulse");
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", cfg_ready); end
    checks++; if (base_tick !== 1'b0) begin errors++; $display("FAIL rst_base_tick: got %b want 0", base_tick); end
    checks++; if (ch_tick !== 4'h0) begin errors++; $display("FAIL rst_ch_tick: got %h want 0", ch_tick); end
    checks++; if (ch_busy !== 4'h0) begin errors++; $display("FAIL rst_ch_busy: got %h want 0", ch_busy); end
    checks++; if (ch_toggle !== 4'h0) begin errors++; $display("FAIL rst_ch_toggle: got %h want 0", ch_toggle); end
    rst_n = 1'b1;
    step();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release: got %b want 1", cfg_ready); end
    // First base tick after the 4th edge since release, then every 4 edges.
    for (int j = 1; j <= 8; j++) begin
      logic exp;
      step();
      exp = (j == 3) || (j == 7);
      checks++;
      if (base_tick !== exp) begin errors++; $display("FAIL base_tick_cadence j=%0d: got %b want %b", j, base_tick, exp); end
      checks++;
      if ((ch_tick !== 4'h0) || (ch_busy !== 4'h0)) begin
        errors++; $display("FAIL idle_outputs j=%0d: tick=%h busy=%h want 0/0", j, ch_tick, ch_busy);
      end
    end
  endtask

  task automatic test_periodic();
    logic exp_tog;
    sync_bt();
    step();
    send_cmd(2'd0, CMD_SET_PERIOD, 8'd3);
    send_cmd(2'd0, CMD_START_PER, 8'd0);
    checks++; if (ch_busy !== 4'b0001) begin errors++; $display("FAIL per_busy: got %b want 0001", ch_busy); end
    exp_tog = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      logic exp;
      step();
      exp = (k == 10) || (k == 22) || (k == 34);
      checks++;
      if (ch_tick[0] !== exp) begin errors++; $display("FAIL per_tick0 k=%0d: got %b want %b", k, ch_tick[0], exp); end
`ifdef TICK_SCHED_TOGGLE_EN
      if (exp) exp_tog = ~exp_tog;
      checks++;
      if (ch_toggle[0] !== exp_tog) begin errors++; $display("FAIL per_toggle0 k=%0d: got %b want %b", k, ch_toggle[0], exp_tog); end
`endif
    end
  endtask

  task automatic test_oneshot();
    sync_bt();
    step();
    send_cmd(2'd1, CMD_SET_PERIOD, 8'd2);
    send_cmd(2'd1, CMD_START_ONE, 8'd0);
    checks++; if (ch_busy[1] !== 1'b1) begin errors++; $display("FAIL one_busy_start: got %b want 1", ch_busy[1]); end
    for (int k = 1; k <= 100; k++) begin
      logic exp_t, exp_b;
      step();
      exp_t = (k == 6);
      exp_b = (k < 6);
      checks++;
      if (ch_tick[1] !== exp_t) begin errors++; $display("FAIL one_tick1 k=%0d: got %b want %b", k, ch_tick[1], exp_t); end
      checks++;
      if (ch_busy[1] !== exp_b) begin errors++; $display("FAIL one_busy1 k=%0d: got %b want %b", k, ch_busy[1], exp_b); end
    end
  endtask

  task automatic test_stop_at_expiry();
    sync_bt();
    step();
    send_cmd(2'd2, CMD_SET_PERIOD, 8'd5);
    send_cmd(2'd2, CMD_START_PER, 8'd0);
    for (int k = 1; k <= 17; k++) begin
      step();
      checks++;
      if (ch_tick[2] !== 1'b0) begin errors++; $display("FAIL stop_pre_tick2 k=%0d: got %b want 0", k, ch_tick[2]); end
    end
    // This cycle carries the 5th base tick: the expiry cycle.
    checks++; if (base_tick !== 1'b1) begin errors++; $display("FAIL stop_align: base_tick got %b want 1", base_tick); end
    send_cmd(2'd2, CMD_STOP, 8'd0);
    checks++; if (ch_tick[2] !== 1'b0) begin errors++; $display("FAIL stop_tick2: got %b want 0", ch_tick[2]); end
    checks++; if (ch_busy[2] !== 1'b0) begin errors++; $display("FAIL stop_busy2: got %b want 0", ch_busy[2]); end
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++;
      if ((ch_tick[2] !== 1'b0) || (ch_busy[2] !== 1'b0)) begin
        errors++; $display("FAIL stop_post k=%0d: tick2=%b busy2=%b want 0/0", k, ch_tick[2], ch_busy[2]);
      end
    end
  endtask

  task automatic test_zero_period_and_retune();
    bit found;
    send_cmd(2'd3, CMD_START_PER, 8'd0);
    checks++; if (ch_busy[3] !== 1'b0) begin errors++; $display("FAIL zero_start_busy3: got %b want 0", ch_busy[3]); end
    send_cmd(2'd3, CMD_SET_PERIOD, 8'd4);
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if ((ch_busy[3] !== 1'b0) || (ch_tick[3] !== 1'b0)) begin
        errors++; $display("FAIL zero_idle3 k=%0d: busy3=%b tick3=%b want 0/0", k, ch_busy[3], ch_tick[3]);
      end
    end
    // Align to a ch0 expiry; its countdown has just reloaded to 3.
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      step();
      if (ch_tick[0]) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL retune_sync: ch_tick0 got 0 for 16 cycles, required a pulse"); end
    send_cmd(2'd0, CMD_SET_PERIOD, 8'd6);
    for (int k = 1; k <= 70; k++) begin
      logic exp;
      step();
      exp = (k == 11) || (k == 35) || (k == 59);
      checks++;
      if (ch_tick[0] !== exp) begin errors++; $display("FAIL retune_tick0 k=%0d: got %b want %b", k, ch_tick[0], exp); end
    end
    checks++; if (ch_busy[3] !== 1'b0) begin errors++; $display("FAIL retune_busy3: got %b want 0", ch_busy[3]); end
    send_cmd(2'd3, CMD_START_PER, 8'd0);
    checks++; if (ch_busy[3] !== 1'b1) begin errors++; $display("FAIL start3_busy: got %b want 1", ch_busy[3]); end
  endtask

  task automatic test_bad_channel();
    cfg_valid5  = 1'b1;
    cfg_ch5     = 3'd5;
    cfg_cmd5    = CMD_SET_PERIOD;
    cfg_period5 = 8'd3;
    step();
    cfg_cmd5    = CMD_START_PER;
    cfg_period5 = 8'd0;
    step();
    cfg_valid5  = 1'b0;
    checks++; if (ch_busy5 !== 5'h00) begin errors++; $display("FAIL badch_busy: got %b want 00000", ch_busy5); end
    // ch1 has period 0, so START must leave it idle unless ch5 aliased onto it.
    cfg_valid5 = 1'b1;
    cfg_ch5    = 3'd1;
    cfg_cmd5   = CMD_START_PER;
    step();
    cfg_valid5 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      checks++;
      if ((ch_busy5 !== 5'h00) || (ch_tick5 !== 5'h00)) begin
        errors++; $display("FAIL badch_state k=%0d: busy=%b tick=%b want 0/0", k, ch_busy5, ch_tick5);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    checks++; if (ch_busy[0] !== 1'b1) begin errors++; $display("FAIL mid_pre_busy0: got %b want 1", ch_busy[0]); end
    rst_n = 1'b0;
    #2;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b want 0", cfg_ready); end
    checks++; if (base_tick !== 1'b0) begin errors++; $display("FAIL mid_base_tick: got %b want 0", base_tick); end
    checks++; if (ch_busy !== 4'h0) begin errors++; $display("FAIL mid_busy: got %h want 0", ch_busy); end
    checks++; if (ch_tick !== 4'h0) begin errors++; $display("FAIL mid_tick: got %h want 0", ch_tick); end
    checks++; if (ch_toggle !== 4'h0) begin errors++; $display("FAIL mid_toggle: got %h want 0", ch_toggle); end
    #2;
    rst_n = 1'b1;
    step();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_release: got %b want 1", cfg_ready); end
    for (int k = 1; k <= 30; k++) begin
      step();
      checks++;
      if ((ch_tick !== 4'h0) || (ch_busy !== 4'h0)) begin
        errors++; $display("FAIL mid_quiet k=%0d: tick=%h busy=%h want 0/0", k, ch_tick, ch_busy);
      end
    end
    // Periods were cleared, so a START is a no-op.
    send_cmd(2'd0, CMD_START_PER, 8'd0);
    checks++; if (ch_busy[0] !== 1'b0) begin errors++; $display("FAIL mid_period_cleared: busy0 got %b want 0", ch_busy[0]); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_stop_at_expiry();
    test_zero_period_and_retune();
    test_bad_channel();
    test_reset_mid_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
